// File: rtl/avalon_pio_in_edge_if.sv
// avalon_pio_in_edge_if: Avalon-MM slave bus bundle for the PIO input port.
// The master drives address/strobes/writedata; the slave returns readdata.
interface avalon_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_in_edge.sv
// avalon_pio_in_edge: Avalon-MM input port with sync, edge capture and irq.
// Define PIO_EDGE_BITCLR_EN for write-1-to-clear EDGECAP; else any write clears all.
module avalon_pio_in_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_EN      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_pio_in_edge_if.slave bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [2:0]       prime_cnt;
    logic             primed;
    logic             wr;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // sync_q[0] takes the raw pin; the oldest stage is the synchronised value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev   <= s;
        end
    end

    // Hold off edge detection until the chain and prev hold real pin values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_cnt == PRIME_LAST) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        edges = '0;
        if (EDGE_TYPE == 0) begin
            edges = s & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edges = ~s & prev;
        end else begin
            edges = s ^ prev;
        end
        edges = edges & {WIDTH{primed}};
    end

    always_comb begin
        clr = '0;
        if (wr && bus.address == 2'd3) begin
`ifdef PIO_EDGE_BITCLR_EN
            clr = bus.writedata[WIDTH-1:0];
`else
            clr = '1;
`endif
        end
    end

    always_comb begin
        rd_next = '0;
        unique case (bus.address)
            2'd0: rd_next[WIDTH-1:0] = s;
            2'd1: rd_next = '0;
            2'd2: rd_next[WIDTH-1:0] = mask;
            2'd3: rd_next[WIDTH-1:0] = capture;
        endcase
    end

    // A new edge beats a simultaneous clear so no event is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture      <= '0;
            mask         <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            capture <= edges | (capture & ~clr);
            if (IRQ_EN != 0 && wr && bus.address == 2'd2) begin
                mask <= bus.writedata[WIDTH-1:0];
            end
            irq          <= (IRQ_EN != 0) && (|(capture & mask));
            bus.readdata <= rd_next;
        end
    end
endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// tb_avalon_pio_in_edge: three differently configured ports on one bus,
// checked by a queue scoreboard against a sampled-history reference model.
module tb_avalon_pio_in_edge;
    localparam int N = 3;

    typedef struct packed {
        logic [N-1:0][31:0] rd;
        logic [N-1:0]       irq;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  pin;
    logic [N-1:0]       irq_v;
    logic [N-1:0][31:0] act_rd;

    exp_t        q[$];
    logic [7:0]  hist[$];
    logic [31:0] m_cap[N];
    logic [31:0] m_mask[N];
    int          vectors;
    int          miscompares;

    avalon_pio_in_edge_if bus0();
    avalon_pio_in_edge_if bus1();
    avalon_pio_in_edge_if bus2();

    assign bus0.address = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;
    assign bus0.writedata = writedata;
    assign bus1.address = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;
    assign bus1.writedata = writedata;
    assign bus2.address = address;
    assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;
    assign bus2.writedata = writedata;
    assign act_rd[0] = bus0.readdata;
    assign act_rd[1] = bus1.readdata;
    assign act_rd[2] = bus2.readdata;

    avalon_pio_in_edge #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .in_port(pin), .irq(irq_v[0])
    );

    avalon_pio_in_edge #(
        .WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_EN(1)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .in_port(pin), .irq(irq_v[1])
    );

    avalon_pio_in_edge #(
        .WIDTH(5), .SYNC_STAGES(4), .EDGE_TYPE(1), .IRQ_EN(0)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .in_port(pin[4:0]), .irq(irq_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_w(int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic int p_ss(int d);
        return d + 2;
    endfunction

    function automatic int p_et(int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic p_ie(int d);
        return d != 2;
    endfunction

    function automatic logic [31:0] wmask(int d);
        return (p_w(d) == 32) ? 32'hFFFF_FFFF : ((32'h1 << p_w(d)) - 32'h1);
    endfunction

    // Pin value sampled at clock edge j after reset release (0 before that)
    function automatic logic [31:0] xs(int j);
        if (j < 0 || j >= hist.size()) return 32'h0;
        return {24'h0, hist[j]};
    endfunction

    // A pin change first seen at sample j lands in capture at sample j+SS;
    // the change from the reset value to sample 1 is never an edge.
    task automatic model_edge();
        exp_t        ex;
        int          k;
        int          ss;
        logic [31:0] wm, sv, sp, e, clr;
        logic        wr;
        k = hist.size();
        hist.push_back(pin);
        wr = chipselect && !write_n;
        for (int d = 0; d < N; d++) begin
            ss = p_ss(d);
            wm = wmask(d);
            sv = xs(k - ss) & wm;
            sp = xs(k - ss - 1) & wm;
            case (p_et(d))
                0: e = sv & ~sp;
                1: e = ~sv & sp & wm;
                default: e = sv ^ sp;
            endcase
            if (k - ss < 2) e = 32'h0;
            case (address)
                2'd0: ex.rd[d] = sv;
                2'd2: ex.rd[d] = m_mask[d];
                2'd3: ex.rd[d] = m_cap[d];
                default: ex.rd[d] = 32'h0;
            endcase
            ex.irq[d] = p_ie(d) && ((m_cap[d] & m_mask[d]) != 0);
            clr = 32'h0;
            if (wr && address == 2'd3) begin
`ifdef PIO_EDGE_BITCLR_EN
                clr = writedata & wm;
`else
                clr = wm;
`endif
            end
            m_cap[d] = e | (m_cap[d] & ~clr);
            if (wr && address == 2'd2 && p_ie(d)) m_mask[d] = writedata & wm;
        end
        q.push_back(ex);
    endtask

    task automatic step(input logic [1:0] a, input logic c,
                        input logic w, input logic [31:0] dat);
        address    = a;
        chipselect = c;
        write_n    = w;
        writedata  = dat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'd0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] dat);
        step(a, 1'b1, 1'b0, dat);
    endtask

    task automatic do_reset();
        exp_t ex;
        #1;
        reset_n = 1'b0;
        hist.delete();
        hist.push_back(8'h00);
        for (int d = 0; d < N; d++) begin
            m_cap[d]  = 32'h0;
            m_mask[d] = 32'h0;
        end
        ex = '0;
        repeat (2) begin
            @(posedge clk);
            q.push_back(ex);
            @(negedge clk);
        end
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                ex = q.pop_front();
                for (int d = 0; d < N; d++) begin
                    vectors++;
                    if (act_rd[d] !== ex.rd[d]) begin
                        miscompares++;
                        $display("FAIL readdata u%0d t=%0t got %h want %h",
                                 d, $time, act_rd[d], ex.rd[d]);
                    end
                    vectors++;
                    if (irq_v[d] !== ex.irq[d]) begin
                        miscompares++;
                        $display("FAIL irq u%0d t=%0t got %b want %b",
                                 d, $time, irq_v[d], ex.irq[d]);
                    end
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        pin         = 8'hFF;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'h0;
        @(negedge clk);
        do_reset();

        // input held high through reset: data visible, nothing captured
        idle(10);
        rd(2'd3);
        rd(2'd3);

        // single rising edge on bit 0 with mask bit 0
        wr(2'd2, 32'h1);
        pin = 8'h00;
        idle(8);
        pin = 8'h01;
        idle(7);
        rd(2'd3);

        // clear all, then build capture 0x05 and clear bit 2
        wr(2'd3, 32'hFFFF_FFFF);
        pin = 8'h00;
        idle(8);
        pin = 8'h05;
        idle(8);
        rd(2'd3);
        wr(2'd3, 32'h4);
        rd(2'd3);
        idle(2);
        wr(2'd3, 32'h0);
        rd(2'd3);
        idle(2);

        // edge on bit 3 arrives in u0 capture on the same edge as a clear
        pin = 8'h00;
        idle(8);
        wr(2'd3, 32'hFFFF_FFFF);
        pin = 8'h08;
        idle(2);
        wr(2'd3, 32'h8);
        rd(2'd3);
        idle(3);

        // any-edge port: bit 7 toggles twice with mask 0, then unmask
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0);
        pin = pin ^ 8'h80;
        idle(10);
        pin = pin ^ 8'h80;
        idle(10);
        rd(2'd3);
        wr(2'd2, 32'h80);
        idle(3);
        rd(2'd2);

        repeat (2) begin
            repeat (500) begin
                if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: rd(2'($urandom));
                    4:       step(2'($urandom), 1'b0, 1'b0, $urandom);
                    5:       wr(2'($urandom), $urandom);
                    6, 7:    wr(2'd2, $urandom);
                    8:       wr(2'd3, $urandom);
                    default: idle(1);
                endcase
            end
            pin = 8'($urandom);
            do_reset();
            idle(6);
        end

        idle(2);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
